dmem_pipe: RTL

Parametrised data memory for the MIPS-class core, next generation of the single-cycle data memory. It adds a registered read with a valid/ready request handshake, per-byte write enables, and out-of-range detection. An optional zero-fill sequencer clears the array after reset. It sits between the core's MEM stage and the word-addressed storage, and serves one request per cycle.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the pipelined data memory (dmem_pipe).
package dmem_pkg;

  typedef enum logic {CLEAR, RUN} dmem_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 1024;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  // A one-word array still needs a one-bit index.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: one synchronous byte-enabled write port and a
// registered read port. Power-up contents are whatever the implementation flow preloads.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       a_i,
  input  logic [DATA_W-1:0]   wd_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                re_i,
  input  logic                rclr_i,
  output logic [DATA_W-1:0]   rd_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) mem_q[a_i][8*i +: 8] <= wd_i[8*i +: 8];
      end
    end
  end

  // Clear has priority so reset and out-of-range reads present zero; otherwise hold.
  always_ff @(posedge clk) begin
    if (rclr_i)    rd_q <= '0;
    else if (re_i) rd_q <= mem_q[a_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/dmem_pipe.sv
// Data memory with valid/ready request, byte enables, 1-cycle registered read and
// out-of-range err. Define DMEM_PIPE_CLEAR_EN to zero-fill the array after reset.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_wd,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rd,
  output logic                err,
  output logic                busy
);

  localparam int NB = lanes(DATA_W);
  localparam int AW = cnt_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic              accept, in_rng;
  logic              arr_we, arr_re, arr_rclr;
  logic [AW-1:0]     arr_a;
  logic [DATA_W-1:0] arr_wd;
  logic [NB-1:0]     arr_be;
  logic              rsp_valid_q, err_q;

  assign in_rng = ({1'b0, req_a} < DEPTH_A);
  assign accept = req_valid && req_ready;

`ifdef DMEM_PIPE_CLEAR_EN
  dmem_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  assign req_ready = rst_n && (state_q == RUN);
  assign busy      = (state_q == CLEAR);

  // While clearing, the write port is owned by the counter and writes zeros.
  always_comb begin
    arr_we = accept && req_we && in_rng;
    arr_a  = req_a[AW-1:0];
    arr_wd = req_wd;
    arr_be = req_be;
    if (state_q == CLEAR) begin
      arr_we = rst_n;
      arr_a  = cnt_q;
      arr_wd = '0;
      arr_be = '1;
    end
  end
`else
  assign req_ready = rst_n;
  assign busy      = 1'b0;

  always_comb begin
    arr_we = accept && req_we && in_rng;
    arr_a  = req_a[AW-1:0];
    arr_wd = req_wd;
    arr_be = req_be;
  end
`endif

  assign arr_re   = accept && !req_we && in_rng;
  assign arr_rclr = !rst_n || (accept && !req_we && !in_rng);

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .a_i    (arr_a),
    .wd_i   (arr_wd),
    .be_i   (arr_be),
    .re_i   (arr_re),
    .rclr_i (arr_rclr),
    .rd_o   (rsp_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= accept && !req_we;
      err_q       <= accept && !in_rng;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;

endmodule
